// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
// Optional feature macro: LSU_MISALIGN_EN (misaligned and word-crossing accesses).
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Unshifted byte mask for the access size encoded in funct3[1:0].
    function automatic logic [3:0] base_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return MASK_BYTE;
            2'd1:    return MASK_HALF;
            default: return MASK_WORD;
        endcase
    endfunction

    // funct3 encodings that name a real load or store.
    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        if (write) return (funct3 <= F3_LW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the {high, low} word pair right by the byte
// offset and sign/zero-extends the result to 32 bits according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [1:0]  offset_in,
    input  logic [2:0]  funct3_in,
    output logic [31:0] result_out
);

    logic [31:0] shifted;

    // Bring the addressed byte to lane 0, then truncate and extend to the access size.
    always_comb begin
        shifted = 32'({hi_in, lo_in} >> {offset_in, 3'b000});
        case (funct3_in)
            F3_LB:   result_out = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result_out = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result_out = shifted;
            F3_LBU:  result_out = {24'b0, shifted[7:0]};
            F3_LHU:  result_out = {16'b0, shifted[15:0]};
            default: result_out = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: one request per handshake, word-aligned byte-enabled
// memory accesses, extended load data on the response channel.
// Optional feature macro: LSU_MISALIGN_EN. When defined, any alignment is legal
// and word-crossing accesses are split into ACC0 + ACC1. When undefined, natural
// alignment is required and the ACC1 path does not exist.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and payload is held stable while valid is
// high and ready is low.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byte_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output lsu_state_e        dbg_state
);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        offset_q, offset_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [3:0]        mem_byte_en_q, mem_byte_en_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              req_ok;
    logic              go_resp;
    logic [31:0]       align_hi;
    logic [31:0]       align_lo;
    logic [31:0]       load_result;

`ifdef LSU_MISALIGN_EN
    logic [2:0]        mask_hi_q, mask_hi_d;
    logic [31:0]       wdata_hi_q, wdata_hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [6:0]        acc_mask;
    logic [63:0]       acc_wdata;

    // Mask and data are widened so bytes pushed past lane 3 land in the next word.
    assign acc_mask  = 7'(base_mask(req_funct3)) << req_addr[1:0];
    assign acc_wdata = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    assign req_ok    = f3_legal(req_write, req_funct3);

    // ACC1 supplies the high word live; the low word was captured in ACC0.
    assign align_hi  = (state_q == ST_ACC1) ? mem_rdata : 32'b0;
    assign align_lo  = (state_q == ST_ACC1) ? lo_q : mem_rdata;
`else
    logic [3:0]        acc_mask;
    logic [31:0]       acc_wdata;
    logic              aligned;

    // Naturally aligned accesses never leave the word, so 4 lanes suffice.
    assign acc_mask  = base_mask(req_funct3) << req_addr[1:0];
    assign acc_wdata = req_wdata << {req_addr[1:0], 3'b000};
    assign aligned   = (req_funct3[1:0] == 2'd1) ? !req_addr[0] :
                       (req_funct3[1:0] == 2'd2) ? (req_addr[1:0] == 2'b00) : 1'b1;
    assign req_ok    = f3_legal(req_write, req_funct3) && aligned;

    assign align_hi  = 32'b0;
    assign align_lo  = mem_rdata;
`endif

    lsu_load_align u_align (
        .hi_in      (align_hi),
        .lo_in      (align_lo),
        .offset_in  (offset_q),
        .funct3_in  (funct3_q),
        .result_out (load_result)
    );

    // Next-state and next-output computation for the request/access/response sequence.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_byte_en_d = mem_byte_en_q;
        mem_wdata_d   = mem_wdata_q;
`ifdef LSU_MISALIGN_EN
        mask_hi_d     = mask_hi_q;
        wdata_hi_d    = wdata_hi_q;
        lo_d          = lo_q;
`endif
        go_resp       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    offset_d    = req_addr[1:0];
                    req_ready_d = 1'b0;
                    if (req_ok) begin
                        state_d       = ST_ACC0;
                        mem_address_d = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_read_d    = !req_write;
                        mem_write_d   = req_write;
                        mem_byte_en_d = acc_mask[3:0];
                        mem_wdata_d   = acc_wdata[31:0];
`ifdef LSU_MISALIGN_EN
                        mask_hi_d     = acc_mask[6:4];
                        wdata_hi_d    = acc_wdata[63:32];
`endif
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'b0;
                    end
                end
            end
            ST_ACC0: begin
`ifdef LSU_MISALIGN_EN
                lo_d = mem_rdata;
                if (mask_hi_q != 3'b000) begin
                    state_d       = ST_ACC1;
                    mem_address_d = mem_address_q + ADDR_W'(4);
                    mem_byte_en_d = {1'b0, mask_hi_q};
                    mem_wdata_d   = wdata_hi_q;
                end else begin
                    go_resp = 1'b1;
                end
`else
                go_resp = 1'b1;
`endif
            end
`ifdef LSU_MISALIGN_EN
            ST_ACC1: begin
                go_resp = 1'b1;
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'b0;
            end
        endcase

        if (go_resp) begin
            state_d       = ST_RESP;
            resp_valid_d  = 1'b1;
            resp_err_d    = 1'b0;
            resp_rdata_d  = write_q ? 32'b0 : load_result;
            mem_address_d = '0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            mem_byte_en_d = 4'b0;
            mem_wdata_d   = 32'b0;
        end
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            funct3_q      <= 3'b0;
            offset_q      <= 2'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'b0;
            resp_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_byte_en_q <= 4'b0;
            mem_wdata_q   <= 32'b0;
`ifdef LSU_MISALIGN_EN
            mask_hi_q     <= 3'b0;
            wdata_hi_q    <= 32'b0;
            lo_q          <= 32'b0;
`endif
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_byte_en_q <= mem_byte_en_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef LSU_MISALIGN_EN
            mask_hi_q     <= mask_hi_d;
            wdata_hi_q    <= wdata_hi_d;
            lo_q          <= lo_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_byte_en = mem_byte_en_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port. Builds with or without LSU_MISALIGN_EN.
// A 128-byte mirrored memory sits on the memory port; a byte-level reference
// model predicts accesses, latency and load results.
module tb_lsu_mem_port;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_en;
    lsu_state_e  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    lsu_mem_port #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- memory on the port ----------------
    logic [31:0] tb_mem [0:31];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_idx = 5'd0;
    logic [31:0] poke_word = 32'd0;

    assign mem_rdata = mem_read ? tb_mem[mem_address[6:2]] : 32'h0;

    always @(posedge clk_in) begin
        if (poke_en) tb_mem[poke_idx] <= poke_word;
        else if (mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) tb_mem[mem_address[6:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    // ---------------- reference model ----------------
    logic [7:0]  model_mem [0:127];
    logic [31:0] exp_addr_q[$];
    logic [3:0]  exp_be_q[$];
    logic [31:0] exp_q[$];

    task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic legal, output logic [31:0] rdata);
        int size, n;
        logic [31:0] ba, wa;
        logic [31:0] v;
        logic [31:0] a_w [2];
        logic [3:0]  be [2];
        logic [31:0] dat [2];
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!MIS && ((addr % size) != 0)) legal = 1'b0;
        exp_addr_q.delete(); exp_be_q.delete(); exp_q.delete();
        rdata = 32'h0;
        v = 32'h0;
        n = 0;
        if (legal) begin
            for (int i = 0; i < size; i++) begin
                ba = addr + i;
                wa = {ba[31:2], 2'b00};
                if (n == 0 || a_w[n-1] != wa) begin
                    a_w[n] = wa; be[n] = 4'b0; dat[n] = 32'h0; n++;
                end
                be[n-1][ba[1:0]] = 1'b1;
                dat[n-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
                if (wr) model_mem[ba[6:0]] = wd[8*i +: 8];
                else    v[8*i +: 8] = model_mem[ba[6:0]];
            end
            for (int k = 0; k < n; k++) begin
                exp_addr_q.push_back(a_w[k]); exp_be_q.push_back(be[k]); exp_q.push_back(dat[k]);
            end
            if (!wr) begin
                case (f3)
                    3'd0: rdata = {{24{v[7]}}, v[7:0]};
                    3'd1: rdata = {{16{v[15]}}, v[15:0]};
                    3'd2: rdata = v;
                    3'd4: rdata = {24'h0, v[7:0]};
                    default: rdata = {16'h0, v[15:0]};
                endcase
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk_in);
        poke_en = 1'b1; poke_idx = a[6:2]; poke_word = w;
        for (int i = 0; i < 4; i++) model_mem[{a[6:2], 2'(i)}] = w[8*i +: 8];
        @(posedge clk_in);
        #1 poke_en = 1'b0;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input string tag);
        int k;
        @(negedge clk_in);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk_in); k++;
        end
        chk({tag, " req_ready"}, req_ready, 1'b1);
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
    endtask

    // One transaction: drive, observe memory accesses until the response, compare.
    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic use_const, input logic c_err,
                         input logic [31:0] c_rdata, input string tag);
        logic        legal;
        logic [31:0] m_rdata;
        int          lat, n_exp;
        logic [31:0] oa[$];
        logic [3:0]  obe[$];
        logic [31:0] od[$];
        logic [1:0]  orw[$];
        model_op(wr, f3, addr, wd, legal, m_rdata);
        n_exp = exp_addr_q.size();
        drive_req(wr, f3, addr, wd, tag);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            if (mem_read || mem_write) begin
                oa.push_back(mem_address); obe.push_back(mem_byte_en);
                od.push_back(mem_wdata); orw.push_back({mem_write, mem_read});
            end
            @(negedge clk_in); lat++;
        end
        chk({tag, " resp_valid"}, resp_valid, 1'b1);
        chk({tag, " latency"}, lat, 1 + n_exp);
        chk({tag, " access count"}, oa.size(), n_exp);
        for (int i = 0; i < n_exp && i < oa.size(); i++) begin
            chk({tag, " addr"}, oa[i], exp_addr_q[i]);
            chk({tag, " byte_en"}, obe[i], exp_be_q[i]);
            chk({tag, " rd/wr"}, orw[i], {wr, !wr});
            if (wr) chk({tag, " wdata"}, od[i] & lane_mask(obe[i]), exp_q[i]);
        end
        chk({tag, " resp_err"}, resp_err, !legal);
        chk({tag, " resp_rdata"}, resp_rdata, m_rdata);
        chk({tag, " mem idle in resp"}, {mem_read, mem_write}, 2'b00);
        if (use_const) begin
            chk({tag, " err const"}, resp_err, c_err);
            chk({tag, " rdata const"}, resp_rdata, c_rdata);
        end
        if (resp_ready) @(posedge clk_in);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [0:19];

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, req_ready, 1'b1);
        chk({tag, " resp_valid"}, resp_valid, 1'b0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, " resp_err"}, resp_err, 1'b0);
        chk({tag, " mem strobes"}, {mem_read, mem_write, mem_byte_en}, 6'h0);
        chk({tag, " mem_address"}, mem_address, 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        logic        lg;
        logic [31:0] rd;
        logic        saw_write;
        logic [31:0] ra;

        vecs[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,        1'b0, 32'hFFFFFF80};
        vecs[1]  = '{1'b0, 3'd4, 32'h103, 32'h0,        1'b0, 32'h00000080};
        vecs[2]  = '{1'b0, 3'd1, 32'h101, 32'h0,        !MIS, 32'h00000000};
        vecs[3]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[4]  = '{1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 3'd5, 32'h102, 32'h0,        1'b0, 32'h0000DEAD};
        vecs[6]  = '{1'b0, 3'd1, 32'h100, 32'h0,        1'b0, 32'hFFFFBEEF};
        vecs[7]  = '{1'b1, 3'd0, 32'h101, 32'h12345655, 1'b0, 32'h00000000};
        vecs[8]  = '{1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 32'hDEAD55EF};
        vecs[9]  = '{1'b0, 3'd0, 32'h101, 32'h0,        1'b0, 32'h00000055};
        vecs[10] = '{1'b0, 3'd3, 32'h100, 32'h0,        1'b1, 32'h00000000};
        vecs[11] = '{1'b0, 3'd6, 32'h100, 32'h0,        1'b1, 32'h00000000};
        vecs[12] = '{1'b0, 3'd7, 32'h100, 32'h0,        1'b1, 32'h00000000};
        vecs[13] = '{1'b1, 3'd4, 32'h100, 32'h0,        1'b1, 32'h00000000};
        vecs[14] = '{1'b1, 3'd3, 32'h100, 32'h0,        1'b1, 32'h00000000};
        vecs[15] = '{1'b1, 3'd1, 32'h107, 32'h0000ABCD, !MIS, 32'h00000000};
        vecs[16] = '{1'b0, 3'd2, 32'h104, 32'h0,        1'b0, MIS ? 32'hCD665544 : 32'h77665544};
        vecs[17] = '{1'b0, 3'd2, 32'h102, 32'h0,        !MIS, MIS ? 32'h5544DEAD : 32'h0};
        vecs[18] = '{1'b1, 3'd2, 32'h106, 32'h01020304, !MIS, 32'h00000000};
        vecs[19] = '{1'b0, 3'd2, 32'h108, 32'h0,        1'b0, MIS ? 32'h00000102 : 32'h0};

        // ---- reset block ----
        rst_in = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b1;
        for (int i = 0; i < 32; i++) poke(32'(i) << 2, 32'h0);
        @(negedge clk_in);
        check_reset_outputs("reset held");
        rst_in = 1'b0;
        @(negedge clk_in);
        check_reset_outputs("after reset");

        // ---- table-driven directed vectors ----
        poke(32'h100, 32'h80000000);
        poke(32'h104, 32'h77665544);
        poke(32'h108, 32'h00000000);
        for (int i = 0; i < 20; i++)
            do_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, 1'b1,
                  vecs[i].err, vecs[i].rdata, $sformatf("vec%0d", i));

        // ---- split load across words ----
        poke(32'h100, 32'h33221100);
        poke(32'h104, 32'h77665544);
        do_op(1'b0, 3'd2, 32'h102, 32'h0, 1'b1, !MIS, MIS ? 32'h55443322 : 32'h0, "lw 0x102");

        // ---- store wrapping past the top of the address space ----
        do_op(1'b1, 3'd2, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b1, !MIS, 32'h0, "sw wrap");
        do_op(1'b0, 3'd2, 32'h00000000, 32'h0, 1'b0, 1'b0, 32'h0, "lw 0x0");
        do_op(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0, 32'h0, "lw 0xfffffffc");

        // ---- response back-pressure ----
        poke(32'h100, 32'hCAFEF00D);
        poke(32'h104, 32'h0BADC0DE);
        resp_ready = 1'b0;
        do_op(1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, "stall lw");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("stall resp_valid", resp_valid, 1'b1);
            chk("stall resp_rdata", resp_rdata, 32'hCAFEF00D);
            chk("stall req_ready", req_ready, 1'b0);
        end
        // Present the next request during the response handshake.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h104; req_wdata = 32'h0;
        resp_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("post handshake resp_valid", resp_valid, 1'b0);
        chk("post handshake req_ready", req_ready, 1'b1);
        chk("post handshake no access", {mem_read, mem_write}, 2'b00);
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
        chk("next acc0 read", mem_read, 1'b1);
        chk("next acc0 addr", mem_address, 32'h104);
        @(negedge clk_in);
        chk("next resp_valid", resp_valid, 1'b1);
        chk("next resp_rdata", resp_rdata, 32'h0BADC0DE);
        @(posedge clk_in);

        // ---- reset during ACC0 of a store ----
        ra = MIS ? 32'hFFFFFFFE : 32'h100;
        drive_req(1'b1, 3'd2, ra, 32'h11223344, "rst store");
        chk("rst store acc0 write", mem_write, 1'b1);
        rst_in = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk_in);
        rst_in = 1'b0;
        saw_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (mem_write) saw_write = 1'b1;
        end
        chk("abort no further write", saw_write, 1'b0);
        check_reset_outputs("after abort");
        do_op(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0, 32'h0, "abort lw hi");
        do_op(1'b0, 3'd2, 32'h00000000, 32'h0, 1'b0, 1'b0, 32'h0, "abort lw lo");
        do_op(1'b0, 3'd2, 32'h00000100, 32'h0, 1'b0, 1'b0, 32'h0, "abort lw 0x100");

        // ---- randomized stimulus against the model ----
        for (int i = 0; i < 200; i++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 1) ? (32'h100 + 32'($urandom_range(0, 15))) : $urandom;
            do_op(wr, f3, a, $urandom, 1'b0, 1'b0, 32'h0, $sformatf("rand%0d", i));
        end

        lg = 1'b0; rd = 32'h0;
        if (lg) rd = 32'h1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
